// File: rtl/mod_init_pkg.sv
// Shared definitions for the byte-to-message packer.
//   state_e    : frame FSM states (hunt for sync, collect bytes, hold message)
//   BYTE_W     : width of one link byte
//   DEF2       : default sync byte value
//   IDX_*      : bit positions inside the bidirectional handshake nibble
package mod_init_pkg;

    localparam int          BYTE_W = 8;
    localparam logic [7:0]  DEF2   = 8'hA5;

    localparam int IDX_BVALID = 0;  // byte_valid, driven by the link side
    localparam int IDX_MVALID = 1;  // msg_valid, driven by this block
    localparam int IDX_ACK    = 2;  // msg_ack, driven by the consumer
    localparam int IDX_ERR    = 3;  // overflow_err, driven by this block

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        HOLD
    } state_e;

endpackage

// File: rtl/mod_init_unit_if.sv
// Data path between the byte link, the packer and the message consumer.
//   port1 : incoming data byte (qualified by the byte_valid handshake bit)
//   port2 : assembled message, registered inside the packer block
// master = the side that supplies bytes and reads messages
// slave  = the packer block itself
interface mod_init_unit_if #(
    parameter int MSG_BITS = 32
);
    logic [7:0]          port1;
    logic [MSG_BITS-1:0] port2;

    modport master (output port1, input  port2);
    modport slave  (input  port1, output port2);
endinterface

// File: rtl/mod_init_packer.sv
// Byte insert/shift register for the message packer.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   shift_en_i    : insert byte_i this edge
//   byte_i        : byte to insert
//   next_o        : register contents including byte_i (the value the
//                   register takes when shift_en_i is high)
// ORDER = 0 : first byte ends up in [7:0] (bytes enter at the top, shift down)
// ORDER = 1 : first byte ends up in [MSG_BITS-1 -: 8] (bytes enter at the bottom, shift up)
module mod_init_packer
    import mod_init_pkg::*;
#(
    parameter int MSG_BITS = 32,
    parameter bit ORDER    = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                shift_en_i,
    input  logic [7:0]          byte_i,
    output logic [MSG_BITS-1:0] next_o
);

    logic [MSG_BITS-1:0] sr_q;
    logic [MSG_BITS-1:0] sr_d;
    logic [MSG_BITS-1:0] inserted;

    // After exactly MSG_BITS/8 inserts every bit has been overwritten, so the
    // register never needs clearing between frames.
    generate
        if (MSG_BITS == BYTE_W) begin : g_single
            assign inserted = byte_i;
        end else if (ORDER == 1'b0) begin : g_lsb_first
            assign inserted = {byte_i, sr_q[MSG_BITS-1:BYTE_W]};
        end else begin : g_msb_first
            assign inserted = {sr_q[MSG_BITS-BYTE_W-1:0], byte_i};
        end
    endgenerate

    assign sr_d   = shift_en_i ? inserted : sr_q;
    assign next_o = inserted;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/mod_init_unit.sv
// Byte-to-message packer.
// Hunts the byte stream for the sync byte, packs the following MSG_BITS/8
// bytes into one message, presents it on port2 with msg_valid and holds it
// until the consumer acknowledges.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : port1 = data byte in, port2 = assembled message out
//   port3  : handshake nibble
//            [0] byte_valid   in  (never driven here)
//            [1] msg_valid    out
//            [2] msg_ack      in  (never driven here)
//            [3] overflow_err out (sticky until reset)
// param1 selects byte order (see mod_init_packer), param2 is the sync byte.
module mod_init_unit
    import mod_init_pkg::*;
#(
    parameter int         MSG_BITS = 32,
    parameter bit         param1   = 1'b0,
    parameter logic [7:0] param2   = DEF2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mod_init_unit_if.slave  bus,
    inout  wire [3:0]       port3
);

    localparam int NBYTES = MSG_BITS / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MSG_BITS-1:0] msg_q, msg_d;
    logic                mvalid_q, mvalid_d;
    logic                err_q, err_d;
    logic                shift_en;
    logic [MSG_BITS-1:0] packed_next;

    wire byte_valid = port3[IDX_BVALID];
    wire msg_ack    = port3[IDX_ACK];

    mod_init_packer #(
        .MSG_BITS (MSG_BITS),
        .ORDER    (param1)
    ) u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .shift_en_i (shift_en),
        .byte_i     (bus.port1),
        .next_o     (packed_next)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        msg_d    = msg_q;
        mvalid_d = mvalid_q;
        err_d    = err_q;
        shift_en = 1'b0;

        case (state_q)
            HUNT: begin
                // Sync byte only opens the frame; it is not message data.
                if (byte_valid && (bus.port1 == param2)) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            end

            COLLECT: begin
                // Sync-valued bytes are plain data here: no resync mid-frame.
                if (byte_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        msg_d    = packed_next;
                        mvalid_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            HOLD: begin
                // A byte arriving while the message is still held is lost;
                // the ack in the same cycle is still honoured.
                if (byte_valid) begin
                    err_d = 1'b1;
                end
                if (msg_ack) begin
                    mvalid_d = 1'b0;
                    state_d  = HUNT;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            msg_q    <= '0;
            mvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            msg_q    <= msg_d;
            mvalid_q <= mvalid_d;
            err_q    <= err_d;
        end
    end

    assign bus.port2 = msg_q;

    // Only the two output bits are driven; bits 0 and 2 are left undriven
    // (high impedance) so the link and consumer own them at all times.
    assign port3[IDX_MVALID] = mvalid_q;
    assign port3[IDX_ERR]    = err_q;

endmodule

// File: tb/tb_mod_init_unit.sv
// Bench for mod_init_unit: two instances (byte order 0 and 1) share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_mod_init_unit;
    import mod_init_pkg::*;

    localparam int MB = 32;
    localparam int NB = MB / 8;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       bv;
    logic       ack;
    logic [7:0] din;

    always #5 clk_i = ~clk_i;

    wire [3:0] p3_le;
    wire [3:0] p3_be;
    assign p3_le[IDX_BVALID] = bv;
    assign p3_le[IDX_ACK]    = ack;
    assign p3_be[IDX_BVALID] = bv;
    assign p3_be[IDX_ACK]    = ack;

    mod_init_unit_if #(.MSG_BITS(MB)) bus_le ();
    mod_init_unit_if #(.MSG_BITS(MB)) bus_be ();
    assign bus_le.port1 = din;
    assign bus_be.port1 = din;

    mod_init_unit #(.MSG_BITS(MB), .param1(1'b0), .param2(DEF2)) dut_le (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_le),
        .port3  (p3_le)
    );

    mod_init_unit #(.MSG_BITS(MB), .param1(1'b1), .param2(DEF2)) dut_be (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_be),
        .port3  (p3_be)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // in_frame: sync seen, bytes being gathered; holding: message waiting for ack.
    bit          m_in_frame;
    bit          m_holding;
    bit          m_valid;
    bit          m_err;
    logic [7:0]  m_bytes[$];
    logic [MB-1:0] m_msg_le;
    logic [MB-1:0] m_msg_be;

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_holding  = 1'b0;
        m_valid    = 1'b0;
        m_err      = 1'b0;
        m_bytes.delete();
        m_msg_le   = '0;
        m_msg_be   = '0;
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] b, input logic a);
        if (m_holding) begin
            if (v) m_err = 1'b1;
            if (a) begin
                m_holding = 1'b0;
                m_valid   = 1'b0;
            end
        end else if (m_in_frame) begin
            if (v) begin
                m_bytes.push_back(b);
                if (m_bytes.size() == NB) begin
                    m_msg_le = '0;
                    m_msg_be = '0;
                    for (int i = 0; i < NB; i++) begin
                        m_msg_le = m_msg_le | (MB'(m_bytes[i]) << (8 * i));
                        m_msg_be = m_msg_be | (MB'(m_bytes[i]) << (8 * (NB - 1 - i)));
                    end
                    m_bytes.delete();
                    m_in_frame = 1'b0;
                    m_holding  = 1'b1;
                    m_valid    = 1'b1;
                end
            end
        end else if (v && (b == DEF2)) begin
            m_in_frame = 1'b1;
            m_bytes.delete();
        end
    endfunction

    // Every-cycle comparison, away from the active edge.
    bit cmp_en = 1'b0;
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("msg_le",    bus_le.port2,        m_msg_le);
            check("msg_be",    bus_be.port2,        m_msg_be);
            check("mvalid_le", p3_le[IDX_MVALID],   MB'(m_valid));
            check("mvalid_be", p3_be[IDX_MVALID],   MB'(m_valid));
            check("err_le",    p3_le[IDX_ERR],      MB'(m_err));
            check("err_be",    p3_be[IDX_ERR],      MB'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic v, input logic [7:0] b, input logic a);
        bv  = v;
        din = b;
        ack = a;
        @(posedge clk_i);
        model_edge(v, b, a);
        @(negedge clk_i);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_ack();
        step(1'b0, 8'h00, 1'b1);
    endtask

    // Asserts reset mid-cycle (asynchronous), releases it away from an edge.
    task automatic pulse_reset();
        #2;
        bv  = 1'b0;
        ack = 1'b0;
        rst_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_ni = 1'b0;
        bv     = 1'b1;
        ack    = 1'b1;
        din    = DEF2;
        model_reset();
        cmp_en = 1'b1;

        // 1: reset state; the DUT must not fight the input bits of port3
        @(negedge clk_i);
        #1;
        check("rst_msg_le",  bus_le.port2, 32'h0);
        check("rst_mvalid",  p3_le[IDX_MVALID], 32'h0);
        check("rst_err",     p3_le[IDX_ERR], 32'h0);
        check("rst_bv_hi",   p3_le[IDX_BVALID], 32'h1);
        check("rst_ack_hi",  p3_be[IDX_ACK], 32'h1);
        bv  = 1'b0;
        ack = 1'b0;
        #1;
        check("rst_bv_lo",   p3_be[IDX_BVALID], 32'h0);
        check("rst_ack_lo",  p3_le[IDX_ACK], 32'h0);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);

        // 2/3: back-to-back frame, both byte orders
        send(8'hA5); send(8'h11); send(8'h22); send(8'h33);
        check("t2_mvalid_before", p3_le[IDX_MVALID], 32'h0);
        send(8'h44);
        check("t2_msg_le", bus_le.port2, 32'h44332211);
        check("t3_msg_be", bus_be.port2, 32'h11223344);
        check("t2_mvalid", p3_le[IDX_MVALID], 32'h1);
        idle(2);
        check("t2_hold",   bus_le.port2, 32'h44332211);
        do_ack();
        check("t2_ack_mvalid", p3_le[IDX_MVALID], 32'h0);
        check("t2_retain",     bus_le.port2, 32'h44332211);

        // 4: hunt skips junk, gap tolerated, sync value inside frame is data
        send(8'h00); send(8'h5A); send(8'hA5); send(8'h11);
        idle(3);
        send(8'h22); send(8'hA5); send(8'h44);
        check("t4_msg_le", bus_le.port2, 32'h44A52211);
        check("t4_msg_be", bus_be.port2, 32'h1122A544);
        check("t4_mvalid", p3_be[IDX_MVALID], 32'h1);

        // 5: byte together with ack in HOLD -> dropped, err sticky, ack honoured
        step(1'b1, 8'h77, 1'b1);
        check("t5_mvalid", p3_le[IDX_MVALID], 32'h0);
        check("t5_err",    p3_le[IDX_ERR], 32'h1);
        check("t5_msg",    bus_le.port2, 32'h44A52211);
        send(8'hA5); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("t5_msg_le", bus_le.port2, 32'h04030201);
        check("t5_err_sticky", p3_be[IDX_ERR], 32'h1);
        do_ack();

        // 6: reset mid-frame discards it; next frame needs a fresh sync
        send(8'hA5); send(8'h11); send(8'h22);
        pulse_reset();
        check("t6_rst_msg",    bus_le.port2, 32'h0);
        check("t6_rst_err",    p3_le[IDX_ERR], 32'h0);
        check("t6_rst_mvalid", p3_le[IDX_MVALID], 32'h0);
        send(8'h33); send(8'h44);
        send(8'hA5); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        check("t6_msg_le", bus_le.port2, 32'hDDCCBBAA);
        check("t6_msg_be", bus_be.port2, 32'hAABBCCDD);
        do_ack();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic       v;
            logic       a;
            logic [7:0] b;
            if ($urandom_range(0, 599) == 0) pulse_reset();
            v = ($urandom_range(0, 99) < 60);
            a = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 3) == 0) ? DEF2 : 8'($urandom);
            step(v, b, a);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
